present_ctr_seq: RTL and testbench
==================================

# present_ctr_seq

Stream sequencer sitting directly upstream of the `present_ctr` core. Accepts a valid/ready stream of 64-bit data blocks, holds the session IV and key, maintains the running block number, restarts the core once per block, and emits the core's XORed result as a valid/ready output stream. It turns the single-shot, reset-driven CTR core into a back-pressured multi-block datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles in RUN before abort (used only with watchdog compiled in).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  session start pulse; honoured only in IDLE.
- iv_i  in  64  session IV, sampled on accepted start.
- key_i  in  80  session key, sampled on accepted start.
- s_valid / s_ready  in / out  1  input block handshake.
- s_data  in  64  input block (plaintext or ciphertext).
- s_last  in  1  marks final block of session.
- m_valid / m_ready  out / in  1  output block handshake.
- m_data  out  64  result block.
- m_last  out  1  copy of s_last for this block.
- core_rst  out  1  drives core `rst`.
- core_iv  out  64  registered session IV.
- core_key  out  80  registered session key.
- core_block_number  out  64  current block number.
- core_block_i  out  64  registered input block.
- core_block_o  in  64  core result.
- core_end  in  1  core end_signal.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky watchdog abort flag (tied 0 without watchdog).

## Operation
- States: IDLE, WAIT_IN, LAUNCH, RUN, OUT.
- IDLE: s_ready=0. On start: latch iv_i, key_i; block number := 0; clear error; go WAIT_IN.
- WAIT_IN: s_ready=1. On s_valid&&s_ready: latch s_data, s_last; go LAUNCH.
- LAUNCH: one cycle, core operands stable, core_rst still 1; go RUN.
- RUN: core_rst=0. On core_end: latch core_block_o into m_data, go OUT. core_end ignored outside RUN.
- OUT: m_valid=1, data/last held stable until m_ready. On handshake: block number += 1; go IDLE if m_last, else WAIT_IN.
- core_rst=1 in every state except RUN, so core end_signal is guaranteed low on RUN entry.
- Block number: 64-bit, unsigned, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 silently.
- start outside IDLE ignored; iv/key changes mid-session have no effect.
- rst asserted in any state: immediate return to IDLE, core re-reset.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, core_rst=1, core_iv=0, core_key=0, core_block_number=0, core_block_i=0, busy=0, error=0.
- Input handshake at cycle t -> LAUNCH t+1 -> RUN t+2; core_end at t+2+L -> m_valid at t+3+L (L = core latency, key schedule plus encryption).
- Output handshake at cycle u -> WAIT_IN (s_ready=1) at u+1; no input accepted while a block is in flight (one block outstanding).
- m_valid never deasserts without m_ready; m_data/m_last stable while m_valid=1.

## Configuration
- PRESENT_CTR_SEQ_TIMEOUT_EN defined: cycle counter runs in RUN; reaching TIMEOUT_CYCLES without core_end sets error=1 (sticky until next accepted start or rst), drops the block, returns to IDLE, block number unchanged.
- Undefined: no counter, RUN waits indefinitely, error tied 0.

## Structure
- Package `present_ctr_pkg`: state enum type, BLOCK_W=64, KEY_W=80, default TIMEOUT_CYCLES.
- One sub-module: `block_counter` (64-bit, synchronous clear on start, increment enable, async reset, natural wrap).
- Core instantiated outside this block; bench connects a real `present_ctr`.

## Test plan
- IV=0, key=0, start, one block s_data=0 with s_last=1 -> m_data=5579C1387B228445, m_last=1, then IDLE, busy=0.
- IV=FFFFFFFFFFFFFFFF, key=all-ones, s_data=FFFFFFFFFFFFFFFF -> m_data=CCCC232CDECDEF2D.
- Three blocks, m_ready held 0 for 10 cycles on block 1 -> m_data stable, s_ready=0 throughout stall, core_block_number sequences 0,1,2.
- Block number preloaded near wrap (force counter to all-ones via bench) -> next block uses 0, no error.
- rst pulsed mid-RUN -> all outputs at reset values next cycle; following session produces correct first block.
- Watchdog build, TIMEOUT_CYCLES=16, core_end held 0 -> error=1 after 16 RUN cycles, state IDLE, m_valid never asserted.

Source files
------------

// File: rtl/present_ctr_pkg.sv
// present_ctr_pkg
//   Shared types and constants for the present_ctr stream sequencer.
//   - seq_state_e        : sequencer FSM states
//   - BLOCK_W / KEY_W    : data block and key widths
//   - TIMEOUT_CYCLES_DEF : default watchdog limit in RUN cycles
package present_ctr_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_LAUNCH,
    ST_RUN,
    ST_OUT
  } seq_state_e;

endpackage

// File: rtl/block_counter.sv
// block_counter
//   64-bit running block number for a CTR session. It wraps silently from
//   all-ones back to zero.
//   Ports:
//     clk, rst : clock and asynchronous active-high reset
//     clr      : synchronous clear; it wins over inc
//     inc      : advance by one
//     count_o  : current block number
module block_counter
  import present_ctr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [BLOCK_W-1:0] count_o
);

  logic [BLOCK_W-1:0] count_d;
  logic [BLOCK_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + BLOCK_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so that every register samples
  // pre-edge values, whatever order the simulator evaluates blocks in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/present_ctr_seq.sv
// present_ctr_seq
//   Stream sequencer in front of the single-shot present_ctr core. It takes
//   one 64-bit block at a time, holds the core in reset while the operands
//   settle, releases it for one run, and presents the result on a
//   valid/ready output. Only one block is in flight at a time.
//   Ports:
//     clk, rst                   : clock, asynchronous active-high reset
//     start, iv_i, key_i         : session start; IV and key are sampled in IDLE only
//     s_valid/s_ready/s_data/s_last : input block stream
//     m_valid/m_ready/m_data/m_last : output block stream
//     core_rst, core_iv, core_key, core_block_number, core_block_i : core drive
//     core_block_o, core_end     : core result and done flag
//     busy                       : high in every state except IDLE
//     error                      : sticky watchdog abort flag
//   Build option: define PRESENT_CTR_SEQ_TIMEOUT_EN to abort a RUN that
//   lasts TIMEOUT_CYCLES cycles without core_end. Without the macro, RUN
//   waits indefinitely and error is tied to 0.
module present_ctr_seq
  import present_ctr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BLOCK_W-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BLOCK_W-1:0] m_data,
  output logic               m_last,
  output logic               core_rst,
  output logic [BLOCK_W-1:0] core_iv,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_block_number,
  output logic [BLOCK_W-1:0] core_block_i,
  input  logic [BLOCK_W-1:0] core_block_o,
  input  logic               core_end,
  output logic               busy,
  output logic               error
);

  seq_state_e         state_d, state_q;
  logic [BLOCK_W-1:0] iv_d, iv_q;
  logic [KEY_W-1:0]   key_d, key_q;
  logic [BLOCK_W-1:0] blk_d, blk_q;
  logic               last_d, last_q;
  logic [BLOCK_W-1:0] mdata_d, mdata_q;
  logic               start_acc;
  logic               out_acc;
  logic               timeout_hit;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign out_acc   = (state_q == ST_OUT) && m_ready;

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    iv_d    = iv_q;
    key_d   = key_q;
    blk_d   = blk_q;
    last_d  = last_q;
    mdata_d = mdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          iv_d    = iv_i;
          key_d   = key_i;
          state_d = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (s_valid) begin
          blk_d   = s_data;
          last_d  = s_last;
          state_d = ST_LAUNCH;
        end
      end
      // One cycle in which the core sees its new operands while still in reset.
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (core_end) begin
          mdata_d = core_block_o;
          state_d = ST_OUT;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = last_q ? ST_IDLE : ST_WAIT_IN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iv_q    <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      iv_q    <= iv_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      mdata_q <= mdata_d;
    end
  end

  block_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .inc     (out_acc),
    .count_o (core_block_number)
  );

`ifdef PRESENT_CTR_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_d, wd_q;
  logic            err_d, err_q;

  // wd_q counts completed RUN cycles; the abort fires in the last allowed one.
  assign timeout_hit = (state_q == ST_RUN) && !core_end &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q;
    if (state_q == ST_RUN) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (start_acc) begin
      err_d = 1'b0;
    end else if (timeout_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  assign s_ready      = (state_q == ST_WAIT_IN);
  assign m_valid      = (state_q == ST_OUT);
  assign m_data       = mdata_q;
  assign m_last       = last_q;
  // The core is held in reset everywhere but RUN, so core_end starts low.
  assign core_rst     = (state_q != ST_RUN);
  assign core_iv      = iv_q;
  assign core_key     = key_q;
  assign core_block_i = blk_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_present_ctr_seq.sv
// tb_present_ctr_seq
//   Drives present_ctr_seq with known-answer and random sessions. A
//   behavioural PRESENT-80 CTR core (E_key(iv + block_number) ^ block) with
//   fixed latency answers the sequencer; a transaction-level model
//   (session IV/key, block count) predicts each output block.
module tb_present_ctr_seq;

  localparam int CORE_L  = 33;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [63:0]  iv_i = '0;
  logic [79:0]  key_i = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [63:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [63:0]  m_data;
  logic         m_last;
  logic         core_rst;
  logic [63:0]  core_iv;
  logic [79:0]  core_key;
  logic [63:0]  core_block_number;
  logic [63:0]  core_block_i;
  logic [63:0]  core_block_o = '0;
  logic         core_end = 1'b0;
  logic         busy;
  logic         error;

  int total = 0;
  int bad   = 0;

  // Session model
  logic [63:0] m_iv;
  logic [79:0] m_key;
  logic [63:0] m_bn;

  bit core_hang = 1'b0;
  int core_cnt  = 0;

  always #5 clk = ~clk;

  present_ctr_seq #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .iv_i(iv_i), .key_i(key_i),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_rst(core_rst), .core_iv(core_iv), .core_key(core_key),
    .core_block_number(core_block_number), .core_block_i(core_block_i),
    .core_block_o(core_block_o), .core_end(core_end),
    .busy(busy), .error(error)
  );

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[4*x +: 4];
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s, t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox(s[4*i +: 4]);
      t = '0;
      for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Behavioural core: released by core_rst, done CORE_L cycles later.
  always @(posedge clk) begin
    if (core_rst) begin
      core_cnt     <= 0;
      core_end     <= 1'b0;
      core_block_o <= {$urandom, $urandom};
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == CORE_L - 1 && !core_hang) begin
        core_end     <= 1'b1;
        core_block_o <= present80(core_key, core_iv + core_block_number) ^ core_block_i;
      end
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 80'(s_ready), 80'(0));
    check({tag, "_m_valid"}, 80'(m_valid), 80'(0));
    check({tag, "_m_data"}, 80'(m_data), 80'(0));
    check({tag, "_m_last"}, 80'(m_last), 80'(0));
    check({tag, "_core_rst"}, 80'(core_rst), 80'(1));
    check({tag, "_core_iv"}, 80'(core_iv), 80'(0));
    check({tag, "_core_key"}, core_key, 80'(0));
    check({tag, "_bn"}, 80'(core_block_number), 80'(0));
    check({tag, "_block_i"}, 80'(core_block_i), 80'(0));
    check({tag, "_busy"}, 80'(busy), 80'(0));
    check({tag, "_error"}, 80'(error), 80'(0));
  endtask

  // Called at a negedge in IDLE.
  task automatic start_session(input logic [63:0] iv, input logic [79:0] key);
    check("idle_busy", 80'(busy), 80'(0));
    start = 1'b1; iv_i = iv; key_i = key;
    @(negedge clk);
    start = 1'b0;
    iv_i  = {$urandom, $urandom};
    key_i = {$urandom, $urandom, 16'($urandom)};
    m_iv = iv; m_key = key; m_bn = '0;
    check("start_s_ready", 80'(s_ready), 80'(1));
    check("start_bn", 80'(core_block_number), 80'(0));
    check("start_error", 80'(error), 80'(0));
  endtask

  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic push_input(input logic [63:0] d, input logic l);
    int n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    check("s_ready_wait", 80'(s_ready), 80'(1));
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    s_valid = 1'b0; s_data = {$urandom, $urandom}; s_last = 1'($urandom);
    check("launch_core_rst", 80'(core_rst), 80'(1));
    check("launch_s_ready", 80'(s_ready), 80'(0));
    check("launch_block_i", 80'(core_block_i), 80'(d));
    check("launch_bn", 80'(core_block_number), 80'(m_bn));
    check("launch_iv", 80'(core_iv), 80'(m_iv));
    check("launch_key", core_key, m_key);
    @(negedge clk);
    check("run_core_rst", 80'(core_rst), 80'(0));
    check("run_s_ready", 80'(s_ready), 80'(0));
    check("run_busy", 80'(busy), 80'(1));
  endtask

  task automatic collect_output(input logic [63:0] d, input logic l, input int stall);
    logic [63:0] exp;
    int n = 0;
    int end_n = -1;
    exp = present80(m_key, m_iv + m_bn) ^ d;
    while (!m_valid && n < 300) begin
      if (core_end && end_n < 0) end_n = n;
      @(negedge clk);
      n++;
    end
    check("m_valid_seen", 80'(m_valid), 80'(1));
    check("end_to_valid", 80'(n - end_n), 80'(1));
    check("m_data", 80'(m_data), 80'(exp));
    check("m_last", 80'(m_last), 80'(l));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_m_valid", 80'(m_valid), 80'(1));
      check("stall_m_data", 80'(m_data), 80'(exp));
      check("stall_s_ready", 80'(s_ready), 80'(0));
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    m_bn = m_bn + 64'd1;
    check("post_m_valid", 80'(m_valid), 80'(0));
    check("post_s_ready", 80'(s_ready), 80'(!l));
    check("post_busy", 80'(busy), 80'(!l));
  endtask

  task automatic run_block(input logic [63:0] d, input logic l, input int stall);
    push_input(d, l);
    collect_output(d, l, stall);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [63:0] d;
    int nblk;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors through the whole path
    start_session('0, '0);
    push_input('0, 1'b1);
    collect_output('0, 1'b1, 0);
    check("kat0_const", 80'(dut.m_data), 80'(64'h5579C1387B228445));
    start_session('1, '1);
    run_block('1, 1'b1, 0);
    check("kat1_const", 80'(m_data), 80'(64'hCCCC232CDECDEF2D));

    // Three blocks, long stall on block 1; mid-session start/iv/key noise
    start_session({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
    run_block({$urandom, $urandom}, 1'b0, 0);
    start = 1'b1; iv_i = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    run_block({$urandom, $urandom}, 1'b0, 10);
    run_block({$urandom, $urandom}, 1'b1, 0);
    check("three_bn_end", 80'(core_block_number), 80'(3));

    // Block number near wrap
    start_session({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
    force dut.u_cnt.count_q = '1;
    @(negedge clk);
    release dut.u_cnt.count_q;
    m_bn = '1;
    run_block({$urandom, $urandom}, 1'b0, 1);
    check("wrap_bn", 80'(core_block_number), 80'(0));
    run_block({$urandom, $urandom}, 1'b1, 0);
    check("wrap_error", 80'(error), 80'(0));

    // Random sessions
    for (int s = 0; s < 4; s++) begin
      start_session({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
      nblk = $urandom_range(1, 3);
      for (int b = 0; b < nblk; b++) begin
        d = {$urandom, $urandom};
        run_block(d, 1'(b == nblk - 1), $urandom_range(0, 4));
      end
    end

    // Reset mid-RUN
    start_session({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
    push_input({$urandom, $urandom}, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrun");
    @(negedge clk);
    check_reset_values("midrun_next");
    rst = 1'b0;
    @(negedge clk);
    start_session('0, '0);
    run_block('0, 1'b1, 0);
    check("after_rst_kat", 80'(m_data), 80'(64'h5579C1387B228445));

`ifdef PRESENT_CTR_SEQ_TIMEOUT_EN
    // Watchdog abort with a silent core
    core_hang = 1'b1;
    start_session({$urandom, $urandom}, {$urandom, $urandom, 16'($urandom)});
    push_input({$urandom, $urandom}, 1'b0);
    for (int i = 1; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (i == TIMEOUT - 1) begin
        check("wd_pre_error", 80'(error), 80'(0));
        check("wd_pre_busy", 80'(busy), 80'(1));
      end
      if (m_valid) check("wd_m_valid", 80'(m_valid), 80'(0));
    end
    @(negedge clk);
    check("wd_error", 80'(error), 80'(1));
    check("wd_busy", 80'(busy), 80'(0));
    check("wd_m_valid_end", 80'(m_valid), 80'(0));
    check("wd_bn", 80'(core_block_number), 80'(0));
    repeat (3) @(negedge clk);
    check("wd_sticky", 80'(error), 80'(1));
    core_hang = 1'b0;
    start_session('1, '1);
    run_block('1, 1'b1, 0);
    check("wd_recover_kat", 80'(m_data), 80'(64'hCCCC232CDECDEF2D));
`else
    check("no_wd_error", 80'(error), 80'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
